// File: rtl/mem_arb_pkg.sv
// Shared definitions for the multi-port memory arbiter: arbitration modes,
// FSM state encoding and index-width helper.
package mem_arb_pkg;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Width needed to index n items, never less than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_fixed_picker.sv
// Combinational winner selection: round-robin from ptr+1, or fixed priority
// where promoted eligible ports take precedence over plain eligible ones.
module rr_fixed_picker
  import mem_arb_pkg::*;
#(
  parameter int   NUM_PORTS = 3,
  parameter int   IDX_W     = 2,
  parameter logic MODE      = ARB_RR
) (
  input  logic [NUM_PORTS-1:0] eligible,
  input  logic [IDX_W-1:0]     ptr,
  input  logic [NUM_PORTS-1:0] promoted,
  output logic [IDX_W-1:0]     winner,
  output logic                 valid
);

  logic [NUM_PORTS-1:0] cand;
  logic [IDX_W-1:0]     rr_win;
  logic [IDX_W-1:0]     fx_win;
  logic                 found;
  int                   idx;

  // Winner search for both policies; the parameter picks which one is used.
  always_comb begin
    rr_win = '0;
    fx_win = '0;
    found  = 1'b0;
    idx    = 0;
    valid  = |eligible;
    cand   = (|(eligible & promoted)) ? (eligible & promoted) : eligible;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx    = (int'(ptr) + k) % NUM_PORTS;
      rr_win = (!found && eligible[idx]) ? IDX_W'(idx) : rr_win;
      found  = found | eligible[idx];
    end
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      fx_win = cand[i] ? IDX_W'(i) : fx_win;
    end
    winner = (MODE == ARB_RR) ? rr_win : fx_win;
  end

endmodule

// File: rtl/multi_port_mem_arbiter.sv
// N-port cache-side arbiter onto a single memory master port, with
// round-robin or fixed priority plus anti-starvation promotion.
module multi_port_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int  NUM_PORTS  = 3,
  parameter int  ADDR_WIDTH = 19,
  parameter int  DATA_WIDTH = 16,
  parameter int  RR_MODE    = 1,
  parameter int  MAX_WAIT   = 4,
  localparam int IDX_W      = idx_width(NUM_PORTS),
  localparam int BSEL_W     = DATA_WIDTH / 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_data_out,
  input  logic [NUM_PORTS-1:0]             port_wr_en,
  input  logic [NUM_PORTS*BSEL_W-1:0]      port_bytesel,
  input  logic [NUM_PORTS-1:0]             port_access,
  output logic [NUM_PORTS-1:0]             port_ack,
  output logic [DATA_WIDTH-1:0]            port_data_in,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_data_out,
  output logic                             mem_wr_en,
  output logic [BSEL_W-1:0]                mem_bytesel,
  output logic                             mem_access,
  input  logic [DATA_WIDTH-1:0]            mem_data_in,
  input  logic                             mem_ack,
  output logic [IDX_W-1:0]                 grant_idx,
  output logic                             busy
);

  localparam logic MODE   = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;
  localparam int   WAIT_W = idx_width(MAX_WAIT + 1);

  state_t                 state;
  state_t                 next_state;
  logic [NUM_PORTS-1:0]   eligible;
  logic [NUM_PORTS-1:0]   promoted;
  logic [IDX_W-1:0]       winner;
  logic [IDX_W-1:0]       rr_ptr;
  logic                   win_valid;
  logic                   grant;
  logic                   complete;
  logic [WAIT_W-1:0]      wait_cnt [NUM_PORTS];

  // A port being acked this cycle is masked so it cannot be re-granted at once.
  assign eligible = port_access & ~port_ack;
  assign grant    = (state == IDLE) && win_valid;
  assign complete = (state == BUSY) && mem_ack;

  always_comb begin
    promoted = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      promoted[i] = (MODE == ARB_FIXED) && (MAX_WAIT != 0) && (int'(wait_cnt[i]) >= MAX_WAIT);
    end
  end

  rr_fixed_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W),
    .MODE      (MODE)
  ) u_picker (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .promoted (promoted),
    .winner   (winner),
    .valid    (win_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (win_valid) next_state = BUSY;
        else           next_state = IDLE;
      end
      BUSY: begin
        if (mem_ack) next_state = IDLE;
        else         next_state = BUSY;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      port_ack     <= '0;
      port_data_in <= '0;
      mem_addr     <= '0;
      mem_data_out <= '0;
      mem_wr_en    <= 1'b0;
      mem_bytesel  <= '0;
      mem_access   <= 1'b0;
      grant_idx    <= '0;
      busy         <= 1'b0;
      rr_ptr       <= IDX_W'(NUM_PORTS - 1);
    end else begin
      port_ack <= '0;
      if (grant) begin
        mem_addr     <= port_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
        mem_data_out <= port_data_out[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
        mem_wr_en    <= port_wr_en[winner];
        mem_bytesel  <= port_bytesel[int'(winner)*BSEL_W +: BSEL_W];
        mem_access   <= 1'b1;
        busy         <= 1'b1;
        grant_idx    <= winner;
        rr_ptr       <= winner;
      end else if (complete) begin
        mem_access <= 1'b0;
        busy       <= 1'b0;
        port_ack   <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << grant_idx;
        if (!mem_wr_en) port_data_in <= mem_data_in;
      end
    end
  end

  // Lost-arbitration counters; only meaningful in fixed-priority mode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PORTS; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if ((MODE == ARB_RR) || !port_access[i]) begin
          wait_cnt[i] <= '0;
        end else if (grant) begin
          if (winner == IDX_W'(i)) begin
            wait_cnt[i] <= '0;
          end else if (eligible[i] && (int'(wait_cnt[i]) < MAX_WAIT)) begin
            wait_cnt[i] <= wait_cnt[i] + WAIT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_port_mem_arbiter.sv
// Bench for multi_port_mem_arbiter: a round-robin and a fixed-priority
// instance driven by directed and random requests against a transaction model.
module tb_multi_port_mem_arbiter;

  localparam int NP = 3, AW = 19, DW = 16, BW = 2, FX_WAIT = 2;

  logic clk = 1'b0;
  logic reset_n;

  logic [NP*AW-1:0] p_addr  [2];
  logic [NP*DW-1:0] p_wdata [2];
  logic [NP-1:0]    p_wr    [2];
  logic [NP*BW-1:0] p_bsel  [2];
  logic [NP-1:0]    p_req   [2];
  logic [NP-1:0]    p_ack   [2];
  logic [DW-1:0]    p_rdata [2];
  logic [AW-1:0]    m_addr  [2];
  logic [DW-1:0]    m_wdata [2];
  logic             m_wr    [2];
  logic [BW-1:0]    m_bsel  [2];
  logic             m_acc   [2];
  logic [DW-1:0]    m_rdata [2];
  logic             m_ack   [2];
  logic [1:0]       gidx    [2];
  logic             bsy     [2];

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] hash(input logic [AW-1:0] a);
    return a[15:0] ^ {a[18:16], 13'h0B5D};
  endfunction

  multi_port_mem_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(1), .MAX_WAIT(4)) dut_rr (
    .clk(clk), .reset_n(reset_n), .port_addr(p_addr[0]), .port_data_out(p_wdata[0]),
    .port_wr_en(p_wr[0]), .port_bytesel(p_bsel[0]), .port_access(p_req[0]), .port_ack(p_ack[0]),
    .port_data_in(p_rdata[0]), .mem_addr(m_addr[0]), .mem_data_out(m_wdata[0]), .mem_wr_en(m_wr[0]),
    .mem_bytesel(m_bsel[0]), .mem_access(m_acc[0]), .mem_data_in(m_rdata[0]), .mem_ack(m_ack[0]),
    .grant_idx(gidx[0]), .busy(bsy[0]));

  multi_port_mem_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(0), .MAX_WAIT(FX_WAIT)) dut_fx (
    .clk(clk), .reset_n(reset_n), .port_addr(p_addr[1]), .port_data_out(p_wdata[1]),
    .port_wr_en(p_wr[1]), .port_bytesel(p_bsel[1]), .port_access(p_req[1]), .port_ack(p_ack[1]),
    .port_data_in(p_rdata[1]), .mem_addr(m_addr[1]), .mem_data_out(m_wdata[1]), .mem_wr_en(m_wr[1]),
    .mem_bytesel(m_bsel[1]), .mem_access(m_acc[1]), .mem_data_in(m_rdata[1]), .mem_ack(m_ack[1]),
    .grant_idx(gidx[1]), .busy(bsy[1]));

  // Memory: ack is mem_access delayed one cycle, read data is a hash of the address.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ack[0] <= 1'b0;
      m_ack[1] <= 1'b0;
    end else begin
      m_ack[0] <= m_acc[0];
      m_ack[1] <= m_acc[1];
    end
  end
  assign m_rdata[0] = hash(m_addr[0]);
  assign m_rdata[1] = hash(m_addr[1]);

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Transaction-level reference state, one set per instance (0 = RR, 1 = fixed).
  bit          e_busy [2], e_acc [2], e_wr [2], e_memack [2], prev_acc [2];
  logic [2:0]  e_ack [2];
  int          e_gidx [2], ptr [2];
  int          losses [2][NP];
  logic [AW-1:0] e_addr [2];
  logic [DW-1:0] e_wdata [2], e_pdata [2];
  logic [BW-1:0] e_bsel [2];
  int          glog0 [$], glog1 [$];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      e_busy[d] = 1'b0; e_acc[d] = 1'b0; e_wr[d] = 1'b0; e_memack[d] = 1'b0; prev_acc[d] = 1'b0;
      e_ack[d] = 3'b000; e_gidx[d] = 0; ptr[d] = NP - 1;
      e_addr[d] = '0; e_wdata[d] = '0; e_pdata[d] = '0; e_bsel[d] = '0;
      for (int p = 0; p < NP; p++) losses[d][p] = 0;
    end
  endtask

  // Predict the effect of the coming clock edge from the inputs now applied.
  task automatic model_step(input int d);
    logic [2:0] elig;
    bit ack_now;
    int win;
    ack_now     = e_memack[d];
    e_memack[d] = e_acc[d];
    elig        = p_req[d] & ~e_ack[d];
    e_ack[d]    = 3'b000;
    for (int p = 0; p < NP; p++) if (!p_req[d][p]) losses[d][p] = 0;
    if (!e_busy[d]) begin
      win = -1;
      if (d == 0) begin
        for (int k = 1; k <= NP; k++) if (win < 0 && elig[(ptr[d] + k) % NP]) win = (ptr[d] + k) % NP;
      end else begin
        for (int p = NP - 1; p >= 0; p--) if (elig[p]) win = p;
        for (int p = NP - 1; p >= 0; p--) if (elig[p] && losses[d][p] >= FX_WAIT) win = p;
      end
      if (win >= 0) begin
        ptr[d] = win; e_gidx[d] = win; e_busy[d] = 1'b1; e_acc[d] = 1'b1;
        e_addr[d]  = p_addr[d][win*AW +: AW];
        e_wdata[d] = p_wdata[d][win*DW +: DW];
        e_wr[d]    = p_wr[d][win];
        e_bsel[d]  = p_bsel[d][win*BW +: BW];
        for (int p = 0; p < NP; p++) begin
          if (p == win) losses[d][p] = 0;
          else if (elig[p]) losses[d][p] = (losses[d][p] + 1 > FX_WAIT) ? FX_WAIT : losses[d][p] + 1;
        end
      end
    end else if (ack_now) begin
      e_ack[d] = 3'b001 << e_gidx[d];
      e_busy[d] = 1'b0; e_acc[d] = 1'b0;
      if (!e_wr[d]) e_pdata[d] = hash(e_addr[d]);
    end
  endtask

  task automatic check_outputs(input int d);
    check_eq($sformatf("mem_access[%0d]", d), m_acc[d], e_acc[d]);
    check_eq($sformatf("busy[%0d]", d), bsy[d], e_busy[d]);
    check_eq($sformatf("port_ack[%0d]", d), p_ack[d], e_ack[d]);
    check_eq($sformatf("grant_idx[%0d]", d), gidx[d], e_gidx[d]);
    check_eq($sformatf("port_data_in[%0d]", d), p_rdata[d], e_pdata[d]);
    if (e_acc[d]) begin
      check_eq($sformatf("mem_addr[%0d]", d), m_addr[d], e_addr[d]);
      check_eq($sformatf("mem_data_out[%0d]", d), m_wdata[d], e_wdata[d]);
      check_eq($sformatf("mem_wr_en[%0d]", d), m_wr[d], e_wr[d]);
      check_eq($sformatf("mem_bytesel[%0d]", d), m_bsel[d], e_bsel[d]);
    end
    if (m_acc[d] && !prev_acc[d]) begin
      if (d == 0) glog0.push_back(int'(gidx[d]));
      else        glog1.push_back(int'(gidx[d]));
    end
    prev_acc[d] = m_acc[d];
  endtask

  task automatic tick();
    for (int d = 0; d < 2; d++) model_step(d);
    @(negedge clk);
    for (int d = 0; d < 2; d++) check_outputs(d);
  endtask

  task automatic set_req(input int d, input int p, input logic [AW-1:0] a, input logic [DW-1:0] w,
                         input logic wr, input logic [BW-1:0] b);
    p_addr[d][p*AW +: AW]  = a;
    p_wdata[d][p*DW +: DW] = w;
    p_wr[d][p]             = wr;
    p_bsel[d][p*BW +: BW]  = b;
    p_req[d][p]            = 1'b1;
  endtask

  task automatic drop_acked();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < NP; p++) if (e_ack[d][p]) p_req[d][p] = 1'b0;
  endtask

  task automatic rand_stim(input int d);
    for (int p = 0; p < NP; p++) begin
      if (p_req[d][p]) begin
        if (e_ack[d][p]) p_req[d][p] = 1'b0;
        else if (e_busy[d] && e_gidx[d] == p && $urandom_range(15) == 0) p_req[d][p] = 1'b0;
      end else if (!(e_busy[d] && e_gidx[d] == p) && $urandom_range(3) == 0) begin
        set_req(d, p, AW'($urandom), DW'($urandom), 1'($urandom_range(1)), BW'($urandom));
      end
    end
  endtask

  int pos2;

  initial begin
    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      p_addr[d] = '0; p_wdata[d] = '0; p_wr[d] = '0; p_bsel[d] = '0; p_req[d] = '0;
    end
    model_reset();
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) tick();
    check_eq("reset mem_access", m_acc[0], 1'b0);
    check_eq("reset port_ack", p_ack[0], 3'b000);
    check_eq("reset busy", bsy[1], 1'b0);

    // Single read on port 1, then single write on port 2.
    set_req(0, 1, 19'h54321, 16'h0000, 1'b0, 2'b11);
    tick();
    check_eq("rd mem_access", m_acc[0], 1'b1);
    check_eq("rd mem_addr", m_addr[0], 19'h54321);
    tick(); tick();
    check_eq("rd port_ack", p_ack[0], 3'b010);
    check_eq("rd data", p_rdata[0], hash(19'h54321));
    drop_acked();
    tick();
    set_req(0, 2, 19'h0ABCD, 16'hBEEF, 1'b1, 2'b01);
    tick();
    check_eq("wr mem_wr_en", m_wr[0], 1'b1);
    check_eq("wr mem_data_out", m_wdata[0], 16'hBEEF);
    check_eq("wr mem_bytesel", m_bsel[0], 2'b01);
    tick(); tick();
    check_eq("wr port_ack", p_ack[0], 3'b100);
    check_eq("wr data held", p_rdata[0], hash(19'h54321));
    drop_acked();
    tick();

    // All ports hammering: RR rotation on instance 0, starvation relief on instance 1.
    glog0.delete();
    glog1.delete();
    for (int p = 0; p < NP; p++) begin
      set_req(0, p, AW'(32'h100 + p), 16'h0000, 1'b0, 2'b11);
      set_req(1, p, AW'(32'h200 + p), 16'h0000, 1'b0, 2'b11);
    end
    repeat (24) tick();
    for (int i = 0; i < 6; i++)
      check_eq($sformatf("rr_order%0d", i), (glog0.size() > i) ? glog0[i] : -1, i % NP);
    pos2 = -1;
    for (int i = glog1.size() - 1; i >= 0; i--) if (glog1[i] == 2) pos2 = i;
    check_eq("starve_pos", pos2, 2);
    p_req[0] = '0; p_req[1] = '0;
    repeat (4) tick();

    // Reset while a transaction is outstanding.
    set_req(0, 2, 19'h7FFFF, 16'h1234, 1'b0, 2'b11);
    set_req(1, 1, 19'h00001, 16'h5678, 1'b1, 2'b10);
    tick();
    check_eq("pre_rst busy", bsy[0], 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst mem_access0", m_acc[0], 1'b0);
    check_eq("rst mem_access1", m_acc[1], 1'b0);
    check_eq("rst port_ack", p_ack[0], 3'b000);
    check_eq("rst busy", bsy[1], 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check_eq("post_rst grant", m_acc[0], 1'b1);
    check_eq("post_rst idx", gidx[0], 2'd2);
    repeat (4) begin tick(); drop_acked(); end

    repeat (800) begin
      rand_stim(0);
      rand_stim(1);
      tick();
    end
    p_req[0] = '0; p_req[1] = '0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_port_mem_arbiter.md
Name: multi_port_mem_arbiter

Overview:
- Parametrised N-port successor to the two-port instruction/data cache arbiter.
- Multiplexes NUM_PORTS cache-side master ports (each read/write) onto one memory master port.
- Arbitration is round-robin or fixed priority with anti-starvation promotion.
- Sits between the I-cache, D-cache and extra masters (DMA, prefetch) and the SDRAM/memory controller.

Parameters:
- NUM_PORTS, 3, number of requesting ports (2..8); port 0 is highest priority in fixed mode.
- ADDR_WIDTH, 19, word address width; this is address bits [19:1].
- DATA_WIDTH, 16, data width; bytesel width is DATA_WIDTH/8.
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority.
- MAX_WAIT, 4, fixed mode only: number of lost arbitrations after which a waiting port is promoted to top priority; 0 disables promotion.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- port_addr  in  NUM_PORTS*ADDR_WIDTH  per-port word address, port i at slice i.
- port_data_out  in  NUM_PORTS*DATA_WIDTH  per-port write data.
- port_wr_en  in  NUM_PORTS  per-port write enable.
- port_bytesel  in  NUM_PORTS*DATA_WIDTH/8  per-port byte enables.
- port_access  in  NUM_PORTS  per-port request; held until ack.
- port_ack  out  NUM_PORTS  per-port one-cycle completion pulse.
- port_data_in  out  DATA_WIDTH  shared read-return data, valid when any port_ack bit is high.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_data_out  out  DATA_WIDTH  memory write data.
- mem_wr_en  out  1  memory write enable.
- mem_bytesel  out  DATA_WIDTH/8  memory byte enables.
- mem_access  out  1  memory request.
- mem_data_in  in  DATA_WIDTH  memory read data.
- mem_ack  in  1  memory completion.
- grant_idx  out  clog2(NUM_PORTS)  index of the active or last granted port.
- busy  out  1  high while a transaction is outstanding.

Behaviour:
- Reset, asynchronous on reset_n low: all outputs 0; state IDLE; RR pointer = NUM_PORTS-1, so port 0 is searched first; wait counters 0. If reset hits mid-transaction, mem_access drops immediately and no ack is issued.
- States: IDLE, BUSY.
- IDLE:
  - Eligible requests = port_access & ~port_ack. A port whose ack is high this cycle is masked, so a requester that drops access on seeing ack is not re-granted.
  - On a clock edge with any eligible request: select the winner; register its addr/data/wr_en/bytesel onto the mem_* outputs; set mem_access=1, busy=1, grant_idx=winner; go to BUSY.
  - mem_access is therefore visible 1 cycle after the request is first sampled.
  - mem_ack in IDLE is ignored.
- BUSY:
  - mem_* outputs are held stable; requests from other ports are not sampled.
  - On the edge where mem_ack=1: mem_access<=0, busy<=0, port_ack[grant_idx]<=1 for exactly 1 cycle.
  - For reads, port_data_in<=mem_data_in. For writes, port_data_in holds its previous value.
  - Go to IDLE; the update rules below apply.
- Latency:
  - Request sampled at edge E0; mem_access high after E0.
  - mem_ack sampled at edge Ek; port_ack high after Ek for one cycle.
  - Minimum back-to-back spacing: ack cycle, then the next grant at the following edge; mem_access is low for at least 1 cycle between transactions.
- Round-robin: the search starts at ptr+1 modulo NUM_PORTS and the first eligible port wins; ptr<=winner on grant.
- Fixed priority:
  - Lowest eligible index wins, unless some eligible port has wait_cnt >= MAX_WAIT; then the lowest-index such promoted port wins.
  - On each grant, every eligible losing port has wait_cnt incremented, saturating at MAX_WAIT; the winner's wait_cnt is cleared.
  - A port that drops access has its wait_cnt cleared.
- The requester must hold addr/data/wr_en/bytesel stable while access is high. Deasserting access while BUSY for that port does not abort: the memory transaction completes and the ack pulse is still issued.
- Simultaneous mem_ack and new requests in BUSY: the ack is serviced first, and the new requests are arbitrated at the next edge.

Decomposition:
- Package mem_arb_pkg: arbitration-mode constants (ARB_RR, ARB_FIXED), state enum (IDLE, BUSY), and a function computing the index width from NUM_PORTS.
- Sub-module rr_fixed_picker: combinational winner selection from the eligible vector, RR pointer and promotion vector. Outputs winner index and valid.
- The top level holds the FSM, the output registers and the wait counters.

Test Plan:
All scenarios use NUM_PORTS=3 and a memory model whose ack is mem_access registered by one cycle.
- Reset: hold reset_n=0 for 5 cycles, release, wait 5 -> mem_access=0, port_ack=0, busy=0.
- Single read: port 1 reads addr 19'h54321 -> mem_access=1 and mem_addr=19'h54321 after 1 edge; port_ack=3'b010 for one cycle after 3 edges; port_data_in equals model data.
- Single write: port 2 writes 16'hBEEF with bytesel 2'b01 at 19'h0ABCD -> mem_wr_en=1, mem_data_out=16'hBEEF, mem_bytesel=2'b01; ack on bit 2 only.
- Round-robin: ports 0, 1 and 2 request continuously, each re-requesting after its ack -> grant order 0,1,2,0,1,2; mem_access low for at least 1 cycle between grants.
- Fixed mode starvation, RR_MODE=0 and MAX_WAIT=2: ports 0 and 1 hammer continuously, port 2 is held -> port 2 is granted no later than its 3rd arbitration.
- Reset mid-BUSY: assert reset_n=0 before mem_ack arrives -> mem_access drops asynchronously; no port_ack pulse afterwards; the next request after release is granted normally.
